palin_detect_nbit: RTL and testbench
====================================

Name: palin_detect_nbit

Overview:
Parametrised serial palindrome detector, the successor to the team's fixed 3-bit Moore palindrome FSM. Accepts one bit per qualified clock and flags when the most recent WIDTH-bit window reads the same forwards and backwards. Supports non-overlapping frames or a sliding window, bit-level valid qualification, and a saturating detection counter. Sits on a serial input path as a pattern monitor.

Parameters:
WIDTH, 5, window length in bits; legal range 2..32.
OVERLAP, 0, 0 = non-overlapping frames of WIDTH bits; 1 = sliding window evaluated on every accepted bit once full.
CNT_W, 8, width of the detection counter.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  serial_in is accepted at this edge only when 1
serial_in  input  1  serial data bit
out  output  1  registered palindrome flag
pal_count  output  CNT_W  saturating count of detections since reset

Behaviour:
- Reset (rst=1 at edge): window register, fill counter, out and pal_count all 0; FSM to S_FILL. rst overrides every other input. Reset mid-frame discards the partial frame.
- Window: on accepted bit, shift left, new bit into bit 0; first-received bit of the window ends up in bit WIDTH-1.
- Palindrome test on next-window value: w[i]==w[WIDTH-1-i] for all i < WIDTH/2; the middle bit is ignored for odd WIDTH.
- FSM states:
  - S_FILL: fewer than WIDTH bits held. Fill counter counts accepted bits. The edge accepting the WIDTH-th bit evaluates the window and moves to S_FULL.
  - S_FULL, OVERLAP=0: the next accepted bit starts a new frame. Fill counter becomes 1 and FSM returns to S_FILL. The old window is not reused.
  - S_FULL, OVERLAP=1: stays in S_FULL. Every accepted bit evaluates the new WIDTH-bit window.
- out: set to 1 at an edge that accepts a window-completing bit whose window is a palindrome. Cleared at every other edge, including in_valid=0 edges. Latency: out high in the cycle immediately after the completing bit's edge.
  - OVERLAP=1: consecutive palindromic windows hold out high continuously.
- pal_count: +1 at each edge that sets out. Holds at all-ones (2^CNT_W-1) and never wraps.
- in_valid=0: window, fill counter and FSM hold. out clears. pal_count holds.

Optional Feature:
Macro PALIN_FLUSH_EN.
- Defined: adds input port flush (1 bit).
  - flush=1 at an edge, with rst=0, clears the window, fill counter and out, and returns the FSM to S_FILL.
  - pal_count is kept.
  - flush beats in_valid: the bit presented with flush is discarded.
- Not defined: no flush port; behaviour exactly as above.

Decomposition:
- Shared package palin_pkg holds:
  - state encoding constants S_FILL=1'b0 and S_FULL=1'b1;
  - a constant giving the fill-counter width, clog2(WIDTH+1);
  - the legal WIDTH bounds.
- One natural sub-module: palin_check.
  - Purely combinational, parametrised by WIDTH.
  - Input: a WIDTH-bit vector. Output: 1 when the vector is a palindrome.
  - The top module instantiates it on the next-window value.

Test Plan:
1. WIDTH=5, OVERLAP=0, in_valid=1; rst, then bits 1,0,1,0,1 -> out=1 for exactly one cycle after 5th edge; pal_count=1.
2. WIDTH=5, OVERLAP=0; bits 1,1,0,0,1 -> out stays 0, pal_count=0. Then bits 0,1,1,1,0 -> out=1 one cycle, pal_count=1.
3. WIDTH=5, stream 1,0,1,0,1,0,1:
   - OVERLAP=1 -> out high for 3 consecutive cycles after bits 5,6,7; pal_count=3.
   - OVERLAP=0 -> single pulse after bit 5; pal_count=1.
4. WIDTH=5, OVERLAP=0; bits 1,0, then in_valid=0 for 3 cycles, then 0,0,1 -> out=0 throughout gap; out=1 after final bit; pal_count=1.
5. WIDTH=4, OVERLAP=0:
   - rst asserted after bits 1,0,0 -> all outputs 0 next cycle;
   - then bits 1,0,0,1 -> out=1 one cycle, pal_count=1 (no pre-reset bits used).
6. WIDTH=3, CNT_W=2, OVERLAP=1, 6 bits of all 1s -> out high for 4 consecutive cycles; pal_count 1,2,3,3 (saturated).
   - With PALIN_FLUSH_EN: flush mid-frame, then bits 0,1,0 -> out=1 once; pal_count unchanged by the flush.

Source files
------------

// File: rtl/palin_pkg.sv
// Shared definitions for the serial palindrome detector: FSM encoding,
// legal window bounds and the fill-counter width helper.
package palin_pkg;

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // The counter must represent 0..width inclusive.
    function automatic int fill_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/palin_check.sv
// Combinational palindrome test on a WIDTH-bit vector; the middle bit of an
// odd-length vector does not take part in the comparison.
module palin_check #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic             o_pal
);

    localparam int HALF = WIDTH / 2;

    logic [HALF-1:0] w_match;

    for (genvar i = 0; i < HALF; i++) begin : g_pair
        assign w_match[i] = (i_vec[i] == i_vec[WIDTH-1-i]);
    end

    assign o_pal = &w_match;

endmodule

// File: rtl/palin_detect_nbit.sv
// Serial WIDTH-bit palindrome detector with framed or sliding windows and a
// saturating hit counter. Optional synchronous flush input: PALIN_FLUSH_EN.
module palin_detect_nbit
    import palin_pkg::*;
#(
    parameter int WIDTH   = 5,
    parameter int OVERLAP = 0,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
`ifdef PALIN_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    input  logic             serial_in,
    output logic             out,
    output logic [CNT_W-1:0] pal_count
);

    localparam int               FILL_W    = fill_cnt_w(WIDTH);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH - 1);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic             SLIDE     = (OVERLAP != 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("palin_detect_nbit: WIDTH out of legal range");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_win;
    logic [WIDTH-1:0]   w_win_nxt;
    logic [WIDTH-1:0]   w_win_shift;
    logic [FILL_W-1:0]  r_fill;
    logic [FILL_W-1:0]  w_fill_nxt;
    logic               r_out;
    logic               w_out_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_flush;
    logic               w_accept;
    logic               w_complete;
    logic               w_pal;

`ifdef PALIN_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // A flushed edge drops the presented bit.
    assign w_accept    = in_valid & ~w_flush;
    assign w_win_shift = {r_win[WIDTH-2:0], serial_in};

    palin_check #(
        .WIDTH (WIDTH)
    ) u_check (
        .i_vec (w_win_shift),
        .o_pal (w_pal)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        if (w_flush) begin
            w_state_nxt = S_FILL;
        end else if (w_accept) begin
            case (r_state)
                S_FILL:  w_state_nxt = (r_fill == FILL_LAST) ? S_FULL : S_FILL;
                S_FULL:  w_state_nxt = SLIDE ? S_FULL : S_FILL;
                default: w_state_nxt = S_FILL;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Datapath and output next values.
    always_comb begin
        w_complete = 1'b0;
        w_fill_nxt = r_fill;
        w_win_nxt  = r_win;
        if (w_flush) begin
            w_fill_nxt = '0;
            w_win_nxt  = '0;
        end else if (w_accept) begin
            w_win_nxt = w_win_shift;
            case (r_state)
                S_FILL: begin
                    w_complete = (r_fill == FILL_LAST);
                    w_fill_nxt = r_fill + FILL_ONE;
                end
                S_FULL: begin
                    // Framed mode: this bit opens a fresh frame.
                    w_complete = SLIDE;
                    w_fill_nxt = SLIDE ? r_fill : FILL_ONE;
                end
                default: begin
                    w_complete = 1'b0;
                    w_fill_nxt = '0;
                end
            endcase
        end else begin
            w_fill_nxt = r_fill;
            w_win_nxt  = r_win;
        end

        w_out_nxt = w_complete & w_pal;

        if (w_out_nxt && (r_count != CNT_MAX)) begin
            w_count_nxt = r_count + CNT_ONE;
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win   <= '0;
            r_fill  <= '0;
            r_out   <= 1'b0;
            r_count <= '0;
        end else begin
            r_win   <= w_win_nxt;
            r_fill  <= w_fill_nxt;
            r_out   <= w_out_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign out       = r_out;
    assign pal_count = r_count;

endmodule

// File: tb/tb_palin_detect_nbit.sv
// Directed checks of palin_detect_nbit over four configurations
// (W5 framed, W5 sliding, W4 framed, W3 sliding with 2-bit counter).
module tb_palin_detect_nbit;

    logic       clk = 1'b0;
    logic       rst_v [4];
    logic       vld   [4];
    logic       din   [4];
    logic       fl    [4];
    logic       out_v [4];
    logic [7:0] cnt0, cnt1, cnt2;
    logic [1:0] cnt3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef PALIN_FLUSH_EN
    `define TB_FLUSH(k) .flush(fl[k]),
`else
    `define TB_FLUSH(k)
`endif

    palin_detect_nbit #(.WIDTH(5), .OVERLAP(0), .CNT_W(8)) u_w5f (
        .clk(clk), .rst(rst_v[0]), `TB_FLUSH(0)
        .in_valid(vld[0]), .serial_in(din[0]), .out(out_v[0]), .pal_count(cnt0));
    palin_detect_nbit #(.WIDTH(5), .OVERLAP(1), .CNT_W(8)) u_w5s (
        .clk(clk), .rst(rst_v[1]), `TB_FLUSH(1)
        .in_valid(vld[1]), .serial_in(din[1]), .out(out_v[1]), .pal_count(cnt1));
    palin_detect_nbit #(.WIDTH(4), .OVERLAP(0), .CNT_W(8)) u_w4f (
        .clk(clk), .rst(rst_v[2]), `TB_FLUSH(2)
        .in_valid(vld[2]), .serial_in(din[2]), .out(out_v[2]), .pal_count(cnt2));
    palin_detect_nbit #(.WIDTH(3), .OVERLAP(1), .CNT_W(2)) u_w3s (
        .clk(clk), .rst(rst_v[3]), `TB_FLUSH(3)
        .in_valid(vld[3]), .serial_in(din[3]), .out(out_v[3]), .pal_count(cnt3));

    task automatic step(input int k, input logic v, input logic b);
        vld[k] = v;
        din[k] = b;
        @(posedge clk);
        #1;
        vld[k] = 1'b0;
    endtask

    // Reset is applied with a valid bit present to show rst wins.
    task automatic do_reset(input int k);
        rst_v[k] = 1'b1;
        vld[k]   = 1'b1;
        din[k]   = 1'b1;
        @(posedge clk);
        #1;
        rst_v[k] = 1'b0;
        vld[k]   = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) do_reset(k);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_v[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_out[%0d]: got %b expected 0", k, out_v[k]);
            end
        end
        checks++;
        if ({cnt0, cnt1, cnt2, cnt3} !== 26'd0) begin
            errors++;
            $display("FAIL reset_count: got %h %h %h %h expected all 0", cnt0, cnt1, cnt2, cnt3);
        end
    endtask

    task automatic test_single_frame();
        logic [4:0] p;
        p = 5'b10101;
        do_reset(0);
        for (int i = 4; i >= 0; i--) begin
            step(0, 1'b1, p[i]);
            checks++;
            if (out_v[0] !== (i == 0)) begin
                errors++;
                $display("FAIL frame1_out bit%0d: got %b expected %b", 4 - i, out_v[0], (i == 0));
            end
        end
        checks++;
        if (cnt0 !== 8'd1) begin
            errors++;
            $display("FAIL frame1_count: got %0d expected 1", cnt0);
        end
        step(0, 1'b0, 1'b0);
        checks++;
        if (out_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL frame1_pulse_width: got %b expected 0", out_v[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] p;
        p = 10'b11001_01110;
        do_reset(0);
        for (int i = 9; i >= 0; i--) begin
            step(0, 1'b1, p[i]);
            checks++;
            if (out_v[0] !== (i == 0)) begin
                errors++;
                $display("FAIL b2b_out bit%0d: got %b expected %b", 9 - i, out_v[0], (i == 0));
            end
            if (i == 5) begin
                checks++;
                if (cnt0 !== 8'd0) begin
                    errors++;
                    $display("FAIL b2b_count_nonpal: got %0d expected 0", cnt0);
                end
            end
        end
        checks++;
        if (cnt0 !== 8'd1) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 1", cnt0);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] s;
        s = 7'b1010101;
        do_reset(1);
        for (int i = 6; i >= 0; i--) begin
            step(1, 1'b1, s[i]);
            checks++;
            if (out_v[1] !== (i <= 2)) begin
                errors++;
                $display("FAIL slide_out bit%0d: got %b expected %b", 7 - i, out_v[1], (i <= 2));
            end
        end
        checks++;
        if (cnt1 !== 8'd3) begin
            errors++;
            $display("FAIL slide_count: got %0d expected 3", cnt1);
        end
        do_reset(0);
        for (int i = 6; i >= 0; i--) begin
            step(0, 1'b1, s[i]);
            checks++;
            if (out_v[0] !== (i == 2)) begin
                errors++;
                $display("FAIL framed_out bit%0d: got %b expected %b", 7 - i, out_v[0], (i == 2));
            end
        end
        checks++;
        if (cnt0 !== 8'd1) begin
            errors++;
            $display("FAIL framed_count: got %0d expected 1", cnt0);
        end
    endtask

    task automatic test_valid_gap();
        logic [4:0] p;
        p = 5'b10001;
        do_reset(0);
        step(0, 1'b1, p[4]);
        step(0, 1'b1, p[3]);
        for (int g = 0; g < 3; g++) begin
            step(0, 1'b0, 1'b1);
            checks++;
            if (out_v[0] !== 1'b0) begin
                errors++;
                $display("FAIL gap_out cycle%0d: got %b expected 0", g, out_v[0]);
            end
        end
        for (int i = 2; i >= 0; i--) step(0, 1'b1, p[i]);
        checks++;
        if (out_v[0] !== 1'b1 || cnt0 !== 8'd1) begin
            errors++;
            $display("FAIL gap_final: got out=%b cnt=%0d expected out=1 cnt=1", out_v[0], cnt0);
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] p;
        p = 4'b1001;
        do_reset(2);
        step(2, 1'b1, 1'b1);
        step(2, 1'b1, 1'b0);
        step(2, 1'b1, 1'b0);
        do_reset(2);
        checks++;
        if (out_v[2] !== 1'b0 || cnt2 !== 8'd0) begin
            errors++;
            $display("FAIL midrst_clear: got out=%b cnt=%0d expected 0 0", out_v[2], cnt2);
        end
        for (int i = 3; i >= 0; i--) begin
            step(2, 1'b1, p[i]);
            checks++;
            if (out_v[2] !== (i == 0)) begin
                errors++;
                $display("FAIL midrst_out bit%0d: got %b expected %b", 3 - i, out_v[2], (i == 0));
            end
        end
        checks++;
        if (cnt2 !== 8'd1) begin
            errors++;
            $display("FAIL midrst_count: got %0d expected 1", cnt2);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt [6];
        exp_cnt = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
        do_reset(3);
        for (int i = 0; i < 6; i++) begin
            step(3, 1'b1, 1'b1);
            checks++;
            if (out_v[3] !== (i >= 2) || cnt3 !== exp_cnt[i]) begin
                errors++;
                $display("FAIL sat bit%0d: got out=%b cnt=%0d expected out=%b cnt=%0d",
                         i + 1, out_v[3], cnt3, (i >= 2), exp_cnt[i]);
            end
        end
        step(3, 1'b0, 1'b1);
        checks++;
        if (out_v[3] !== 1'b0 || cnt3 !== 2'd3) begin
            errors++;
            $display("FAIL sat_idle: got out=%b cnt=%0d expected 0 3", out_v[3], cnt3);
        end
    endtask

`ifdef PALIN_FLUSH_EN
    // Flush after two bits; a stale fill would complete 1101 early.
    task automatic test_flush();
        logic [3:0] p;
        p = 4'b0110;
        step(2, 1'b1, 1'b1);
        step(2, 1'b1, 1'b1);
        fl[2] = 1'b1;
        step(2, 1'b1, 1'b0);
        fl[2] = 1'b0;
        checks++;
        if (out_v[2] !== 1'b0 || cnt2 !== 8'd1) begin
            errors++;
            $display("FAIL flush_hold: got out=%b cnt=%0d expected 0 1", out_v[2], cnt2);
        end
        for (int i = 3; i >= 0; i--) begin
            step(2, 1'b1, p[i]);
            checks++;
            if (out_v[2] !== (i == 0)) begin
                errors++;
                $display("FAIL flush_out bit%0d: got %b expected %b", 3 - i, out_v[2], (i == 0));
            end
        end
        checks++;
        if (cnt2 !== 8'd2) begin
            errors++;
            $display("FAIL flush_count: got %0d expected 2", cnt2);
        end
    endtask
`endif

    initial begin
        for (int k = 0; k < 4; k++) begin
            rst_v[k] = 1'b1;
            vld[k]   = 1'b0;
            din[k]   = 1'b0;
            fl[k]    = 1'b0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overlap();
        test_valid_gap();
        test_mid_reset();
        test_saturate();
`ifdef PALIN_FLUSH_EN
        test_flush();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
